// File: rtl/regfile_multi_port.sv
// Multi-port register file with per-register pending (scoreboard) bits and a registered pending count.
// Optional same-cycle write/reserve forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_multi_port #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  localparam int NUM_WIDTH = $clog2(REG_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS*NUM_WIDTH-1:0]  rdNum,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rdData,
  output logic [RD_PORTS-1:0]            rdPending,
  input  logic [WR_PORTS-1:0]            wrEnable,
  input  logic [WR_PORTS*NUM_WIDTH-1:0]  wrNum,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wrData,
  input  logic                           rsvEnable,
  input  logic [NUM_WIDTH-1:0]           rsvNum,
  output logic [NUM_WIDTH:0]             pendingCount
);

  logic [DATA_WIDTH-1:0] r_regs [REG_NUM];
  logic [REG_NUM-1:0]    r_pend;
  logic [NUM_WIDTH:0]    r_pend_cnt;

  logic [DATA_WIDTH-1:0] w_wr_data [REG_NUM];
  logic [REG_NUM-1:0]    w_wr_hit;
  logic [REG_NUM-1:0]    w_rsv_mask;
  logic [REG_NUM-1:0]    w_pend_next;
  logic [NUM_WIDTH:0]    w_pend_cnt_next;

  // Ports are scanned in ascending order so the highest-index enabled port wins a collision.
  always_comb begin
    w_wr_hit = '0;
    for (int unsigned n = 0; n < REG_NUM; n++) begin
      w_wr_data[n] = '0;
    end
    for (int unsigned j = 0; j < WR_PORTS; j++) begin
      if (wrEnable[j]) begin
        w_wr_hit[wrNum[j*NUM_WIDTH +: NUM_WIDTH]]  = 1'b1;
        w_wr_data[wrNum[j*NUM_WIDTH +: NUM_WIDTH]] = wrData[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_rsv_mask = '0;
    if (rsvEnable) begin
      w_rsv_mask[rsvNum] = 1'b1;
    end
    // A write clears pending unless the same register is reserved again this cycle.
    w_pend_next = (r_pend & ~(w_wr_hit & ~w_rsv_mask)) | w_rsv_mask;
  end

  always_comb begin
    w_pend_cnt_next = '0;
    for (int unsigned n = 0; n < REG_NUM; n++) begin
      w_pend_cnt_next = w_pend_cnt_next + (NUM_WIDTH+1)'(w_pend_next[n]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs     <= '{default: '0};
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      for (int unsigned n = 0; n < REG_NUM; n++) begin
        if (w_wr_hit[n]) begin
          r_regs[n] <= w_wr_data[n];
        end
      end
      r_pend     <= w_pend_next;
      r_pend_cnt <= w_pend_cnt_next;
    end
  end

  always_comb begin
    rdData    = '0;
    rdPending = '0;
    if (rst) begin
      for (int unsigned i = 0; i < RD_PORTS; i++) begin
`ifdef REGFILE_BYPASS_EN
        rdData[i*DATA_WIDTH +: DATA_WIDTH] = w_wr_hit[rdNum[i*NUM_WIDTH +: NUM_WIDTH]]
                                           ? w_wr_data[rdNum[i*NUM_WIDTH +: NUM_WIDTH]]
                                           : r_regs[rdNum[i*NUM_WIDTH +: NUM_WIDTH]];
        rdPending[i] = w_pend_next[rdNum[i*NUM_WIDTH +: NUM_WIDTH]];
`else
        rdData[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[rdNum[i*NUM_WIDTH +: NUM_WIDTH]];
        rdPending[i] = r_pend[rdNum[i*NUM_WIDTH +: NUM_WIDTH]];
`endif
      end
    end
  end

  assign pendingCount = r_pend_cnt;

endmodule

// File: tb/tb_regfile_multi_port.sv
// Directed self-checking bench for regfile_multi_port at default parameters.
module tb_regfile_multi_port;

  logic        clk;
  logic        rst;
  logic [9:0]  rdNum;
  logic [63:0] rdData;
  logic [1:0]  rdPending;
  logic [1:0]  wrEnable;
  logic [9:0]  wrNum;
  logic [63:0] wrData;
  logic        rsvEnable;
  logic [4:0]  rsvNum;
  logic [5:0]  pendingCount;

  int n_checks = 0;
  int n_bad    = 0;

  regfile_multi_port #(
    .DATA_WIDTH(32),
    .REG_NUM(32),
    .RD_PORTS(2),
    .WR_PORTS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdNum(rdNum),
    .rdData(rdData),
    .rdPending(rdPending),
    .wrEnable(wrEnable),
    .wrNum(wrNum),
    .wrData(wrData),
    .rsvEnable(rsvEnable),
    .rsvNum(rsvNum),
    .pendingCount(pendingCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEnable  = 2'b00;
    rsvEnable = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    rdNum     = {5'd1, 5'd0};
    wrEnable  = 2'b00;
    wrNum     = '0;
    wrData    = '0;
    rsvEnable = 1'b0;
    rsvNum    = '0;
    #1;
    check("rst_rd0", rdData[31:0], 32'd0);
    check("rst_cnt", {26'd0, pendingCount}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // $0=15 via port0, $1=14 via port1
    wrEnable = 2'b11;
    wrNum    = {5'd1, 5'd0};
    wrData   = {32'd14, 32'd15};
    step(); idle(); #1;
    check("w01_rd0", rdData[31:0], 32'd15);
    check("w01_rd1", rdData[63:32], 32'd14);

    // both ports to $5, port1 wins
    wrEnable = 2'b11;
    wrNum    = {5'd5, 5'd5};
    wrData   = {32'd11, 32'd10};
    rdNum    = {5'd5, 5'd5};
    step(); idle(); #1;
    check("coll_rd0", rdData[31:0], 32'd11);

    // reserve $3, then write it
    rsvEnable = 1'b1; rsvNum = 5'd3;
    rdNum = {5'd0, 5'd3};
    step(); idle(); #1;
    check("rsv3_pend", {31'd0, rdPending[0]}, 32'd1);
    check("rsv3_cnt", {26'd0, pendingCount}, 32'd1);
    wrEnable = 2'b01; wrNum = {5'd0, 5'd3}; wrData = {32'd0, 32'd12};
    step(); idle(); #1;
    check("wr3_pend", {31'd0, rdPending[0]}, 32'd0);
    check("wr3_cnt", {26'd0, pendingCount}, 32'd0);
    check("wr3_data", rdData[31:0], 32'd12);

    // reserve and write $7 in the same cycle
    rsvEnable = 1'b1; rsvNum = 5'd7;
    wrEnable = 2'b10; wrNum = {5'd7, 5'd0}; wrData = {32'd8, 32'd0};
    rdNum = {5'd6, 5'd7};
    step(); idle(); #1;
    check("rw7_data", rdData[31:0], 32'd8);
    check("rw7_pend", {31'd0, rdPending[0]}, 32'd1);
    check("rw7_cnt", {26'd0, pendingCount}, 32'd1);

    // re-reserve pending $7, write non-pending $6
    rsvEnable = 1'b1; rsvNum = 5'd7;
    wrEnable = 2'b01; wrNum = {5'd0, 5'd6}; wrData = {32'd0, 32'd20};
    step(); idle(); #1;
    check("rr7_cnt", {26'd0, pendingCount}, 32'd1);
    check("rr7_pend", {31'd0, rdPending[0]}, 32'd1);
    check("w6_pend", {31'd0, rdPending[1]}, 32'd0);
    check("w6_data", rdData[63:32], 32'd20);

    // disabled enables must be ignored
    wrEnable = 2'b00; wrNum = {5'd7, 5'd7}; wrData = {32'd99, 32'd98};
    rsvEnable = 1'b0; rsvNum = 5'd9;
    step(); #1;
    check("dis_data", rdData[31:0], 32'd8);
    check("dis_cnt", {26'd0, pendingCount}, 32'd1);

    // same-cycle visibility of a write to $2 and of pend clear on $7
    rdNum = {5'd7, 5'd2};
    wrEnable = 2'b11; wrNum = {5'd7, 5'd2}; wrData = {32'd9, 32'd13};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd2", rdData[31:0], 32'd13);
    check("byp_rd7", rdData[63:32], 32'd9);
    check("byp_pend7", {31'd0, rdPending[1]}, 32'd0);
`else
    check("nobyp_rd2", rdData[31:0], 32'd0);
    check("nobyp_rd7", rdData[63:32], 32'd8);
    check("nobyp_pend7", {31'd0, rdPending[1]}, 32'd1);
`endif
    step(); idle(); #1;
    check("post_rd2", rdData[31:0], 32'd13);
    check("post_pend7", {31'd0, rdPending[1]}, 32'd0);
    check("post_cnt", {26'd0, pendingCount}, 32'd0);

    // fill $0..$7 with 100+n, two per cycle
    for (int k = 0; k < 8; k += 2) begin
      wrEnable = 2'b11;
      wrNum    = {5'(k + 1), 5'(k)};
      wrData   = {32'(100 + k + 1), 32'(100 + k)};
      step();
    end
    idle();
    rsvEnable = 1'b1; rsvNum = 5'd4;
    step(); idle();
    rdNum = {5'd0, 5'd4}; #1;
    check("fill_rd4", rdData[31:0], 32'd104);
    check("fill_rd0", rdData[63:32], 32'd100);
    check("fill_cnt", {26'd0, pendingCount}, 32'd1);

    // mid-cycle reset with a write and reserve in flight
    wrEnable = 2'b01; wrNum = {5'd0, 5'd4}; wrData = {32'd0, 32'd77};
    rsvEnable = 1'b1; rsvNum = 5'd5;
    #2;
    rst = 1'b0;
    #1;
    check("mrst_cnt", {26'd0, pendingCount}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      rdNum = {5'(7 - k), 5'(k)};
      #1;
      check("mrst_rd0", rdData[31:0], 32'd0);
      check("mrst_rd1", rdData[63:32], 32'd0);
      check("mrst_pend", {30'd0, rdPending}, 32'd0);
    end
    step();
    rdNum = {5'd5, 5'd4}; #1;
    check("rstedge_rd4", rdData[31:0], 32'd0);
    check("rstedge_cnt", {26'd0, pendingCount}, 32'd0);

    // release reset mid-cycle; the next edge performs the first update
    wrEnable = 2'b01; wrNum = {5'd0, 5'd4}; wrData = {32'd0, 32'd55};
    rsvEnable = 1'b1; rsvNum = 5'd6;
    #1;
    rst = 1'b1;
    step(); idle();
    rdNum = {5'd6, 5'd4}; #1;
    check("rel_rd4", rdData[31:0], 32'd55);
    check("rel_pend6", {31'd0, rdPending[1]}, 32'd1);
    check("rel_cnt", {26'd0, pendingCount}, 32'd1);
    rdNum = {5'd0, 5'd1}; #1;
    check("rel_rd1", rdData[31:0], 32'd0);
    check("rel_rd0", rdData[63:32], 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
